// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read adapter: occupancy states and the default data width.
package fifo_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_e;

    function automatic logic [1:0] occ_count(input occ_state_e s);
        case (s)
            ONE:     occ_count = 2'd1;
            TWO:     occ_count = 2'd2;
            default: occ_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order output buffer; head_o is always the oldest buffered word.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int Data_width = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic [1:0]            occ_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [Data_width-1:0] push_data_i,
    output logic [Data_width-1:0] head_o
);

    logic [Data_width-1:0] head_q, head_d;
    logic [Data_width-1:0] tail_q, tail_d;

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (clear_i) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (occ_i == 2'd0) head_d = push_data_i;
                    else               tail_d = push_data_i;
                end
                2'b01: head_d = tail_q;
                2'b11: begin
                    if (occ_i == 2'd1) begin
                        head_d = push_data_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the two entries are reset explicitly so out_data reads 0 after reset, not stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign head_o = head_q;

endmodule

// File: rtl/fifo_rd_adapter.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream.
// Optional pop counter output word_cnt is enabled by defining FIFO_RD_ADAPTER_CNT_EN.
module fifo_rd_adapter
    import fifo_pkg::*;
#(
    parameter int Data_width = DATA_WIDTH_DEFAULT,
    parameter int Depth      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [Data_width-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Data_width-1:0] out_data
`ifdef FIFO_RD_ADAPTER_CNT_EN
    ,
    output logic [15:0]           word_cnt
`endif
);

    localparam logic [2:0] LIMIT = 3'(Depth);

    occ_state_e state_q, state_d;
    logic       inflight_q, inflight_d;
    logic       pop;
    logic       capture;
    logic [2:0] held;

    assign pop     = out_valid && out_ready;
    assign capture = inflight_q;

    // Words already owned by the adapter: buffered plus the one still on the FIFO read bus.
    assign held       = {1'b0, occ_count(state_q)} + {2'b00, inflight_q};
    assign fifo_rd_en = !fifo_empty && !flush && !rst && (held < LIMIT + {2'b00, pop});
    assign inflight_d = fifo_rd_en && !flush;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case ({capture, pop})
                2'b10: state_d = (state_q == EMPTY) ? ONE : TWO;
                2'b01: state_d = (state_q == TWO) ? ONE : EMPTY;
                default: ;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
    end

    fifo_skid_buf #(
        .Data_width (Data_width)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (flush),
        .occ_i       (occ_count(state_q)),
        .push_i      (capture),
        .pop_i       (pop),
        .push_data_i (fifo_rd_data),
        .head_o      (out_data)
    );

`ifdef FIFO_RD_ADAPTER_CNT_EN
    logic [15:0] word_cnt_q, word_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (flush)    word_cnt_d = '0;
        else if (pop) word_cnt_d = word_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) word_cnt_q <= '0;
        else     word_cnt_q <= word_cnt_d;
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule
